// File: rtl/trisc_pkg.sv
// trisc_pkg: widths and opcode constants shared by the TRISC datapath and instruction decoder.
package trisc_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam logic [3:0] LDA = 4'h1;
    localparam logic [3:0] STA = 4'h2;
    localparam logic [3:0] ADD = 4'h3;
    localparam logic [3:0] SUB = 4'h4;
    localparam logic [3:0] XOR = 4'h5;
    localparam logic [3:0] INC = 4'h6;
    localparam logic [3:0] CLR = 4'h7;
    localparam logic [3:0] JMP = 4'h8;
    localparam logic [3:0] JPZ = 4'h9;
    localparam logic [3:0] JPN = 4'hA;
    localparam logic [3:0] HLT = 4'hF;
endpackage

// File: rtl/trisc_datapath_if.sv
// trisc_datapath_if: controller strobes, program-load port and status returned by the datapath.
interface trisc_datapath_if
    import trisc_pkg::*;
#(
    parameter int DATA_W = trisc_pkg::DATA_W,
    parameter int ADDR_W = trisc_pkg::ADDR_W
);
    logic c0, c1, c2, c3, c4, c5, c7, c8, c9, c10, c11, c12, c13, c14;
    logic load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic w, x, y, z;
    logic [DATA_W-1:0] acc_out;
    logic [ADDR_W-1:0] pc_out;
    logic zero, neg;
    modport master (
        output c0, c1, c2, c3, c4, c5, c7, c8, c9, c10, c11, c12, c13, c14,
        output load_en, load_addr, load_data,
        input w, x, y, z, acc_out, pc_out, zero, neg
    );
    modport slave (
        input c0, c1, c2, c3, c4, c5, c7, c8, c9, c10, c11, c12, c13, c14,
        input load_en, load_addr, load_data,
        output w, x, y, z, acc_out, pc_out, zero, neg
    );
endinterface

// File: rtl/trisc_ram.sv
// trisc_ram: 16x8 program/data RAM with load-port write priority and a two-cycle read into MDR.
module trisc_ram
    import trisc_pkg::*;
#(
    parameter int DATA_W = trisc_pkg::DATA_W,
    parameter int ADDR_W = trisc_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] mdr
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [1:0] rd_cnt;
    always_ff @(posedge clock) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (wr_en) mem[addr] <= wr_data;
    end
    assign rd_data = mem[addr];
    // MDR captures once at least one earlier consecutive c4 cycle has been seen
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt <= 2'd0;
            mdr    <= '0;
        end else begin
            rd_cnt <= rd ? (rd_cnt == 2'd2 ? 2'd2 : rd_cnt + 2'd1) : 2'd0;
            if (rd && rd_cnt != 2'd0) mdr <= rd_data;
        end
    end
endmodule

// File: rtl/trisc_datapath.sv
// trisc_datapath: TRISC accumulator datapath executing controller strobes over PC, MAR, IR, ACC, ALU and RAM.
module trisc_datapath
    import trisc_pkg::*;
#(
    parameter int DATA_W = trisc_pkg::DATA_W,
    parameter int ADDR_W = trisc_pkg::ADDR_W
) (
    input logic clock,
    input logic reset,
    trisc_datapath_if.slave bus
);
    logic [ADDR_W-1:0] pc, mar, pc_next, mar_next;
    logic [DATA_W-1:0] ir, acc, acc_next, mdr, rd_data;
    trisc_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clock(clock), .reset(reset), .addr(mar), .rd(bus.c4),
        .wr_en(bus.c5), .wr_data(acc),
        .load_en(bus.load_en), .load_addr(bus.load_addr), .load_data(bus.load_data),
        .rd_data(rd_data), .mdr(mdr)
    );
    always_comb begin
        pc_next  = bus.c0 ? '0 : bus.c1 ? ir[ADDR_W-1:0] : bus.c2 ? pc + ADDR_W'(1) : pc;
        mar_next = bus.c3 ? pc : bus.c10 ? ir[ADDR_W-1:0] : mar;
        acc_next = bus.c8  ? '0 :
                   bus.c11 ? mdr :
                   bus.c14 ? acc + mdr :
                   bus.c12 ? acc - mdr :
                   bus.c13 ? acc ^ mdr :
                   bus.c9  ? acc + DATA_W'(1) : acc;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc  <= '0;
            mar <= '0;
            ir  <= '0;
            acc <= '0;
        end else begin
            pc  <= pc_next;
            mar <= mar_next;
            acc <= acc_next;
            if (bus.c7) ir <= rd_data;
        end
    end
    assign {bus.w, bus.x, bus.y, bus.z} = ir[DATA_W-1:DATA_W-4];
    assign bus.acc_out = acc;
    assign bus.pc_out  = pc;
    assign bus.zero    = (acc == '0);
    assign bus.neg     = acc[DATA_W-1];
endmodule

// File: tb/tb_trisc_datapath.sv
// tb_trisc_datapath: directed strobe sequences with a queued scoreboard checked by a negedge monitor.
module tb_trisc_datapath;
    import trisc_pkg::*;
    localparam logic [14:0] C0 = 15'h0001, C1 = 15'h0002, C2 = 15'h0004, C3 = 15'h0008;
    localparam logic [14:0] C4 = 15'h0010, C5 = 15'h0020, C7 = 15'h0080, C8 = 15'h0100;
    localparam logic [14:0] C9 = 15'h0200, C10 = 15'h0400, C11 = 15'h0800, C12 = 15'h1000;
    localparam logic [14:0] C13 = 15'h2000, C14 = 15'h4000;
    typedef struct {
        string name;
        int sel;
        logic [7:0] val;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [14:0] s = '0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t m_e;
    logic [7:0] act;
    trisc_datapath_if bus ();
    trisc_datapath dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    assign {bus.c14, bus.c13, bus.c12, bus.c11, bus.c10, bus.c9, bus.c8, bus.c7} = s[14:7];
    assign {bus.c5, bus.c4, bus.c3, bus.c2, bus.c1, bus.c0} = s[5:0];
    // sel: 0 acc, 1 pc, 2 opcode nibble, 3 zero, 4 neg
    always @(negedge clock) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            act = m_e.sel == 0 ? bus.acc_out :
                  m_e.sel == 1 ? {4'h0, bus.pc_out} :
                  m_e.sel == 2 ? {4'h0, bus.w, bus.x, bus.y, bus.z} :
                  m_e.sel == 3 ? {7'h0, bus.zero} : {7'h0, bus.neg};
            checks++;
            if (act !== m_e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", m_e.name, act, m_e.val);
            end
        end
    end
    task automatic expect_v(input string name, input int sel, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.sel = sel;
        e.val = val;
        q.push_back(e);
    endtask
    task automatic cyc(input logic [14:0] v);
        @(negedge clock);
        s = v;
        @(posedge clock);
        #1 s = '0;
    endtask
    task automatic ld(input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.load_en = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        @(posedge clock);
        #1 bus.load_en = 1'b0;
    endtask
    task automatic rd2();
        cyc(C4);
        cyc(C4);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        bus.load_en = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        expect_v("reset_acc", 0, 8'h00);
        expect_v("reset_pc", 1, 8'h00);
        expect_v("reset_op", 2, 8'h00);
        expect_v("reset_zero", 3, 8'h01);
        expect_v("reset_neg", 4, 8'h00);
        ld(4'd0, 8'h1A);
        ld(4'd10, 8'h05);
        cyc(C0);
        cyc(C3);
        rd2();
        cyc(C7 | C2);
        expect_v("fetch_op", 2, 8'h01);
        expect_v("fetch_pc", 1, 8'h01);
        cyc(C10);
        rd2();
        cyc(C11);
        expect_v("lda_acc", 0, 8'h05);
        expect_v("lda_zero", 3, 8'h00);
        cyc(C9);
        cyc(C9);
        expect_v("inc_acc", 0, 8'h07);
        cyc(C5);
        rd2();
        cyc(C8);
        cyc(C11);
        expect_v("sta_readback", 0, 8'h07);
        cyc(C8);
        cyc(C9);
        cyc(C5);
        rd2();
        cyc(C8);
        cyc(C12);
        expect_v("sub_borrow", 0, 8'hFF);
        cyc(C14);
        expect_v("add_wrap", 0, 8'h00);
        expect_v("add_zero", 3, 8'h01);
        cyc(C12);
        expect_v("sub_acc", 0, 8'hFF);
        expect_v("sub_neg", 4, 8'h01);
        cyc(C13);
        expect_v("xor_acc", 0, 8'hFE);
        cyc(C5);
        cyc(C4);
        cyc('0);
        cyc(C8);
        cyc(C11);
        expect_v("lone_c4", 0, 8'h01);
        cyc(C4);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clock);
        s = C4;
        @(posedge clock);
        #1 s = '0;
        cyc(C9);
        cyc(C11);
        expect_v("reset_mid_read", 0, 8'h00);
        expect_v("reset_ir", 2, 8'h00);
        cyc(C2);
        expect_v("pc_inc", 1, 8'h01);
        cyc(C0 | C1 | C2);
        expect_v("pc_prio", 1, 8'h00);
        cyc(C9);
        cyc(C8 | C9);
        expect_v("acc_prio", 0, 8'h00);
        repeat (3) cyc(C2);
        cyc(C3);
        ld(4'd3, 8'h11);
        rd2();
        cyc(C8);
        cyc(C11);
        expect_v("acc_11", 0, 8'h11);
        @(negedge clock);
        s = C5;
        bus.load_en = 1'b1;
        bus.load_addr = 4'd3;
        bus.load_data = 8'hAA;
        @(posedge clock);
        #1 begin
            s = '0;
            bus.load_en = 1'b0;
        end
        rd2();
        cyc(C11);
        expect_v("load_prio", 0, 8'hAA);
        repeat (12) cyc(C2);
        expect_v("pc_15", 1, 8'h0F);
        cyc(C2);
        expect_v("pc_wrap", 1, 8'h00);
        repeat (15) cyc(C2);
        expect_v("pc_end", 1, 8'h0F);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
